// File: rtl/apb_slave_regmem.sv
// -----------------------------------------------------------------------------
// apb_slave_regmem
//
// APB3 completer backed by a word-addressed register memory of DEPTH 32-bit
// entries. Every transfer is stretched by WAIT_STATES access cycles with
// pready held low. Address, direction and write data are captured in the
// setup cycle and used for the whole transfer.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, 2..4096)
//   WAIT_STATES  pready-low access cycles per transfer (0..15)
//
// Ports
//   pclk     in   1   bus clock, rising edge
//   prst     in   1   synchronous active-high reset (clears memory too)
//   psel     in   1   slave select
//   penable  in   1   access-phase strobe
//   paddr    in   32  byte address, word index = paddr[2 +: log2(DEPTH)]
//   pwrite   in   1   1 = write, 0 = read
//   pwdata   in   32  write data
//   prdata   out  32  registered read data, holds until the next read
//   pready   out  1   registered transfer-complete, high one cycle/transfer
// -----------------------------------------------------------------------------
module apb_slave_regmem #(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic        pclk,
   input  logic        prst,
   input  logic        psel,
   input  logic        penable,
   input  logic [31:0] paddr,
   input  logic        pwrite,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = 4;
   localparam bit ZERO_WAIT = (WAIT_STATES == 0);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t          state_q,    state_d;
   logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
   logic            pready_q,   pready_d;
   logic [31:0]     prdata_q,   prdata_d;
   logic [AW-1:0]   idx_q,      idx_d;
   logic            in_range_q, in_range_d;
   logic            write_q,    write_d;
   logic [31:0]     wdata_q,    wdata_d;

   logic [31:0]     mem_q [DEPTH];
   logic            mem_we;

   // Decode of the live bus address, used only at the setup edge.
   logic [AW-1:0]   live_idx;
   logic            live_in_range;
   logic            addr_lsb_unused;

   assign live_idx        = paddr[2 +: AW];
   assign live_in_range   = (paddr[31:AW+2] == '0);
   assign addr_lsb_unused = ^paddr[1:0];   // byte lane bits carry no meaning

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      pready_d   = pready_q;
      prdata_d   = prdata_q;
      idx_d      = idx_q;
      in_range_d = in_range_q;
      write_d    = write_q;
      wdata_d    = wdata_q;
      mem_we     = 1'b0;

      case (state_q)
         IDLE: begin
            pready_d = 1'b0;
            // penable without a setup cycle is not a transfer; stay put.
            if (psel && !penable) begin
               state_d    = ACCESS;
               idx_d      = live_idx;
               in_range_d = live_in_range;
               write_d    = pwrite;
               wdata_d    = pwdata;
               wait_cnt_d = CW'(WAIT_STATES);
               pready_d   = ZERO_WAIT;
               // With no wait states the read data must already be valid
               // in the first access cycle, so sample the live address.
               if (ZERO_WAIT && !pwrite) begin
                  prdata_d = live_in_range ? mem_q[live_idx] : 32'h0;
               end
            end
         end

         ACCESS: begin
            if (!psel) begin
               // Master abandoned the transfer: no write, back to idle.
               state_d    = IDLE;
               pready_d   = 1'b0;
               wait_cnt_d = '0;
            end else if (penable) begin
               if (pready_q) begin
                  // Completion edge: retire the transfer.
                  mem_we     = write_q && in_range_q;
                  pready_d   = 1'b0;
                  state_d    = IDLE;
                  wait_cnt_d = '0;
               end else if (wait_cnt_q != '0) begin
                  wait_cnt_d = wait_cnt_q - CW'(1);
                  if (wait_cnt_q == CW'(1)) begin
                     pready_d = 1'b1;
                     if (!write_q) begin
                        prdata_d = in_range_q ? mem_q[idx_q] : 32'h0;
                     end
                  end
               end
            end
         end

         default: begin
            state_d  = IDLE;
            pready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge pclk) begin
      if (prst) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         pready_q   <= 1'b0;
         prdata_q   <= '0;
         idx_q      <= '0;
         in_range_q <= 1'b0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         pready_q   <= pready_d;
         prdata_q   <= prdata_d;
         idx_q      <= idx_d;
         in_range_q <= in_range_d;
         write_q    <= write_d;
         wdata_q    <= wdata_d;
         if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
         end
      end
   end

   assign prdata = prdata_q;
   assign pready = pready_q;

endmodule

// File: tb/tb_apb_slave_regmem.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regmem
//
// Directed bench for apb_slave_regmem. Two instances share the bus wires
// except psel: dut_w2 (WAIT_STATES=2) and dut_w0 (WAIT_STATES=0). penable
// alone never starts a transfer, so the unselected instance stays idle.
// -----------------------------------------------------------------------------
module tb_apb_slave_regmem;

   logic        pclk;
   logic        prst;
   logic        psel_w2, psel_w0;
   logic        penable;
   logic [31:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata_w2, prdata_w0;
   logic        pready_w2, pready_w0;

   int errors = 0;
   int checks = 0;

   apb_slave_regmem #(.DEPTH(256), .WAIT_STATES(2)) dut_w2 (
      .pclk    (pclk),
      .prst    (prst),
      .psel    (psel_w2),
      .penable (penable),
      .paddr   (paddr),
      .pwrite  (pwrite),
      .pwdata  (pwdata),
      .prdata  (prdata_w2),
      .pready  (pready_w2)
   );

   apb_slave_regmem #(.DEPTH(256), .WAIT_STATES(0)) dut_w0 (
      .pclk    (pclk),
      .prst    (prst),
      .psel    (psel_w0),
      .penable (penable),
      .paddr   (paddr),
      .pwrite  (pwrite),
      .pwdata  (pwdata),
      .prdata  (prdata_w0),
      .pready  (pready_w0)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   // One full transfer. Called right after an edge (+1); returns right after
   // the completion edge (+1) with the bus idle, so a following call issues
   // its setup in the very next cycle.
   task automatic xfer(input bit use_w0, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input int exp_wait, input string tag);
      int cycles;
      logic rdy;
      psel_w0 = use_w0;
      psel_w2 = !use_w0;
      penable = 1'b0;
      paddr   = addr;
      pwrite  = wr;
      pwdata  = wdata;
      tick();                         // setup edge
      penable = 1'b1;
      // Scramble the bus; captured setup values must be used.
      paddr   = ~addr;
      pwrite  = !wr;
      pwdata  = ~wdata;
      cycles  = 0;
      rdy     = use_w0 ? pready_w0 : pready_w2;
      while (!rdy && cycles < 32) begin
         tick();
         cycles++;
         rdy = use_w0 ? pready_w0 : pready_w2;
      end
      chk({tag, "_waits"}, 32'(cycles), 32'(exp_wait));
      if (!wr) chk({tag, "_rdata"}, use_w0 ? prdata_w0 : prdata_w2, exp_rdata);
      tick();                         // completion edge
      chk({tag, "_rdy_low"}, {31'b0, use_w0 ? pready_w0 : pready_w2}, 32'h0);
      psel_w0 = 1'b0;
      psel_w2 = 1'b0;
      penable = 1'b0;
   endtask

   initial begin
      prst    = 1'b1;
      psel_w2 = 1'b0;
      psel_w0 = 1'b0;
      penable = 1'b0;
      paddr   = '0;
      pwrite  = 1'b0;
      pwdata  = '0;
      repeat (3) tick();
      prst = 1'b0;

      // Reset state
      chk("rst_pready_w2", {31'b0, pready_w2}, 32'h0);
      chk("rst_prdata_w2", prdata_w2, 32'h0);
      chk("rst_pready_w0", {31'b0, pready_w0}, 32'h0);
      chk("rst_prdata_w0", prdata_w0, 32'h0);

      // 1: two wait states, write then readback
      xfer(1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_1234, 32'h0, 2, "t1_wr");
      xfer(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hA5A5_1234, 2, "t1_rd");
      xfer(1'b0, 1'b1, 32'h0000_0014, 32'h7777_0001, 32'h0, 2, "t1_wr2");
      chk("t1_prdata_hold", prdata_w2, 32'hA5A5_1234);

      // 2: zero wait, back-to-back
      xfer(1'b1, 1'b1, 32'h0000_0000, 32'h1, 32'h0, 0, "t2_wr0");
      xfer(1'b1, 1'b1, 32'h0000_0004, 32'h2, 32'h0, 0, "t2_wr4");
      xfer(1'b1, 1'b1, 32'h0000_0008, 32'h3, 32'h0, 0, "t2_wr8");
      xfer(1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h1, 0, "t2_rd0");
      xfer(1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h2, 0, "t2_rd4");
      xfer(1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h3, 0, "t2_rd8");

      // 3: out of range
      xfer(1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0, 2, "t3_wr0");
      xfer(1'b0, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0, 2, "t3_wr_oor");
      xfer(1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678, 2, "t3_rd0");
      xfer(1'b0, 1'b0, 32'h0000_0400, 32'h0, 32'h0, 2, "t3_rd_oor");
      xfer(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hA5A5_1234, 2, "t3_rd10");
      xfer(1'b0, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 2, "t3_rd_hi");

      // 4: abort by dropping psel after one wait cycle
      psel_w2 = 1'b1;
      penable = 1'b0;
      paddr   = 32'h0000_0020;
      pwrite  = 1'b1;
      pwdata  = 32'h1111_1111;
      tick();
      penable = 1'b1;
      tick();
      chk("t4_wait1", {31'b0, pready_w2}, 32'h0);
      psel_w2 = 1'b0;
      penable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_no_rdy", {31'b0, pready_w2}, 32'h0);
      end
      xfer(1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h0, 2, "t4_rd20");

      // 5: reset mid-transfer
      xfer(1'b0, 1'b1, 32'h0000_0020, 32'h5555_AAAA, 32'h0, 2, "t5_wr");
      xfer(1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h5555_AAAA, 2, "t5_rd");
      psel_w2 = 1'b1;
      penable = 1'b0;
      paddr   = 32'h0000_0020;
      pwrite  = 1'b1;
      pwdata  = 32'h0;
      tick();
      penable = 1'b1;
      tick();
      prst    = 1'b1;
      psel_w2 = 1'b0;
      penable = 1'b0;
      tick();
      prst = 1'b0;
      chk("t5_rst_pready", {31'b0, pready_w2}, 32'h0);
      chk("t5_rst_prdata", prdata_w2, 32'h0);
      xfer(1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h0, 2, "t5_rd_after");
      xfer(1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h0, 0, "t5_w0_cleared");

      // 6: unaligned read and stray penable
      xfer(1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 2, "t6_wr");
      xfer(1'b0, 1'b0, 32'h0000_0013, 32'h0, 32'hCAFE_F00D, 2, "t6_rd13");
      penable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_pen_nosel_w2", {31'b0, pready_w2}, 32'h0);
         chk("t6_pen_nosel_w0", {31'b0, pready_w0}, 32'h0);
      end
      psel_w2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_pen_in_idle", {31'b0, pready_w2}, 32'h0);
      end
      psel_w2 = 1'b0;
      penable = 1'b0;
      tick();
      xfer(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 2, "t6_rd_after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
